adder_16bit: RTL and testbench

- 16-bit unsigned binary adder with registered sum and carry-out.
- General-purpose arithmetic leaf block for datapaths that need a 17-bit result (carry plus sum) one clock after the operands are presented.
- The core is a ripple chain of single-bit full adders; its outputs are captured in a register stage clocked by clk.

---
 rtl/adder_16bit_pkg.sv | 9 +
 rtl/adder_16bit_if.sv | 26 ++
 rtl/adder_16bit_full_adder.sv | 16 +
 rtl/adder_16bit.sv | 43 ++++
 tb/tb_adder_16bit.sv | 106 ++++++++++
 5 files changed

// File: rtl/adder_16bit_pkg.sv
// Shared constants and types for the registered ripple-carry adder.
// The default width lives here so that the interface, the adder and the bench agree on it.
package adder_16bit_pkg;

  localparam int ADDER_WIDTH = 16;

  typedef logic [ADDER_WIDTH-1:0] word_t;

endpackage : adder_16bit_pkg

// File: rtl/adder_16bit_if.sv
// Operand/result bundle for adder_16bit.
// The master side presents the operands, and the slave (the adder) returns the registered result.
interface adder_16bit_if #(
  parameter int WIDTH = adder_16bit_pkg::ADDER_WIDTH
);

  logic [WIDTH-1:0] d_1;
  logic [WIDTH-1:0] d_2;
  logic [WIDTH-1:0] Sum;
  logic             Cout;

  modport master (
    output d_1,
    output d_2,
    input  Sum,
    input  Cout
  );

  modport slave (
    input  d_1,
    input  d_2,
    output Sum,
    output Cout
  );

endinterface : adder_16bit_if

// File: rtl/adder_16bit_full_adder.sv
// Single-bit full adder; this is one link of the ripple chain in adder_16bit.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic half_sum;

  assign half_sum = a ^ b;
  assign s        = half_sum ^ cin;
  assign cout     = (a & b) | (cin & half_sum);

endmodule : full_adder

// File: rtl/adder_16bit.sv
// WIDTH-bit unsigned ripple-carry adder with the {carry, sum} result registered once.
// The carry-in is tied low, and a synchronous active-high rst clears the result register.
module adder_16bit #(
  parameter int WIDTH = adder_16bit_pkg::ADDER_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  adder_16bit_if.slave bus
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_comb;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  assign carry[0] = 1'b0;

  // Bit i's carry-out feeds bit i+1, and carry[WIDTH] is the adder's carry-out.
  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    full_adder u_fa (
      .a    (bus.d_1[i]),
      .b    (bus.d_2[i]),
      .cin  (carry[i]),
      .s    (sum_comb[i]),
      .cout (carry[i+1])
    );
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values, so ordering between flops cannot matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_comb;
      cout_q <= carry[WIDTH];
    end
  end

  assign bus.Sum  = sum_q;
  assign bus.Cout = cout_q;

endmodule : adder_16bit

// File: tb/tb_adder_16bit.sv
// Self-checking bench for adder_16bit. A 17-bit arithmetic reference is delayed one clock,
// and the bench also confirms that the outputs hold their value until the next rising edge.
module tb_adder_16bit;
  import adder_16bit_pkg::*;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  logic [ADDER_WIDTH:0] exp_q;
  bit                   exp_valid;

  adder_16bit_if #(.WIDTH(ADDER_WIDTH)) bus ();

  adder_16bit #(.WIDTH(ADDER_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [ADDER_WIDTH:0] got,
                       input logic [ADDER_WIDTH:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got {Cout,Sum}=%h, expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge.
  // The previous result must still be present just after the new operands are applied,
  // and the new result must be present just after the next rising edge.
  task automatic drive(input logic r, input word_t a, input word_t b, input string tag);
    @(negedge clk);
    rst     = r;
    bus.d_1 = a;
    bus.d_2 = b;
    #1;
    if (exp_valid) check({tag, "_hold"}, {bus.Cout, bus.Sum}, exp_q);
    @(posedge clk);
    #1;
    exp_q     = r ? '0 : ({1'b0, a} + {1'b0, b});
    exp_valid = 1'b1;
    check(tag, {bus.Cout, bus.Sum}, exp_q);
  endtask

  word_t dir_a [9] = '{16'h0000, 16'h0001, 16'h0007, 16'h0014, 16'hFFFF,
                       16'hFFFF, 16'h8000, 16'h7FFF, 16'hAAAA};
  word_t dir_b [9] = '{16'h0000, 16'h0002, 16'h000A, 16'h001E, 16'h0001,
                       16'hFFFF, 16'h8000, 16'h0001, 16'h5555};

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    exp_valid    = 1'b0;
    exp_q        = '0;
    rst          = 1'b1;
    bus.d_1      = '0;
    bus.d_2      = '0;

    // Hold reset for two cycles with live operands, then release it.
    drive(1'b1, 16'h1234, 16'h1111, "reset_0");
    drive(1'b1, 16'h1234, 16'h1111, "reset_1");
    check("reset_literal", {bus.Cout, bus.Sum}, 17'h0_0000);
    drive(1'b0, 16'h1234, 16'h1111, "reset_release");
    check("release_literal", {bus.Cout, bus.Sum}, 17'h0_2345);

    // Directed sums, back to back, with no idle cycles between them.
    for (int i = 0; i < 9; i++) drive(1'b0, dir_a[i], dir_b[i], $sformatf("dir_%0d", i));

    // Fixed literals for the boundary cases.
    drive(1'b0, 16'hFFFF, 16'h0001, "wrap_ffff_1");
    check("wrap_ffff_1_literal", {bus.Cout, bus.Sum}, 17'h1_0000);
    drive(1'b0, 16'hFFFF, 16'hFFFF, "wrap_ffff_ffff");
    check("wrap_ffff_ffff_literal", {bus.Cout, bus.Sum}, 17'h1_FFFE);
    drive(1'b0, 16'h7FFF, 16'h0001, "ripple_7fff");
    check("ripple_7fff_literal", {bus.Cout, bus.Sum}, 17'h0_8000);

    // Assert reset for one cycle in the middle of a stream, then resume the stream.
    drive(1'b0, 16'h0100, 16'h0200, "stream_0");
    drive(1'b1, 16'h0300, 16'h0400, "stream_rst");
    check("stream_rst_literal", {bus.Cout, bus.Sum}, 17'h0_0000);
    drive(1'b0, 16'h0500, 16'h0600, "stream_resume");
    check("stream_resume_literal", {bus.Cout, bus.Sum}, 17'h0_0B00);

    // Random operand pairs, with occasional all-ones operands and rare reset pulses.
    for (int i = 0; i < 10000; i++) begin
      word_t a, b;
      logic  r;
      a = word_t'($urandom);
      b = word_t'($urandom);
      if ($urandom_range(15) == 0) a = '1;
      if ($urandom_range(15) == 0) b = '1;
      r = ($urandom_range(63) == 0);
      drive(r, a, b, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_adder_16bit
